// File: rtl/mac_tile_simd.sv
// Systolic PE: stationary weights, west->east activation/instruction pass, north->south psum.
// Optional MAC_TILE_WFLUSH_EN: inst_w==11 flushes the weights instead of acting as execute.
module mac_tile_simd #(
  parameter int bw      = 4,
  parameter int psum_bw = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [bw-1:0]      in_w,
  output logic [bw-1:0]      out_e,
  input  logic [1:0]         inst_w,
  output logic [1:0]         inst_e,
  input  logic [psum_bw-1:0] in_n,
  output logic [psum_bw-1:0] out_s,
  input  logic               act_mode
);

  localparam int HW = bw / 2;

  typedef enum logic [1:0] {
    W_EMPTY = 2'd0,
    W_HALF  = 2'd1,
    W_READY = 2'd2
  } wstate_t;

  wstate_t                   r_wstate;
  wstate_t                   w_wstate_nxt;
  logic [bw-1:0]             r_a;
  logic signed [bw-1:0]      r_b1;
  logic signed [bw-1:0]      r_b2;
  logic signed [psum_bw-1:0] r_c;
  logic [1:0]                r_inst;
  logic                      r_mode;

  logic w_load;
  logic w_exec;
  logic w_flush;
  logic w_wr_b1;
  logic w_wr_b2;

  logic [bw-1:0]             w_a_lo;
  logic [bw-1:0]             w_a_hi;
  logic signed [psum_bw-1:0] w_p0;
  logic signed [psum_bw-1:0] w_p1;
  logic signed [psum_bw-1:0] w_p2;

  // Unsigned activation times signed weight, both widened to the psum width.
  function automatic logic signed [psum_bw-1:0] mul_uw(input logic [bw-1:0] a,
                                                        input logic signed [bw-1:0] w);
    logic signed [psum_bw-1:0] ae;
    logic signed [psum_bw-1:0] we;
    ae = $signed({{(psum_bw-bw){1'b0}}, a});
    we = $signed({{(psum_bw-bw){w[bw-1]}}, w});
    return ae * we;
  endfunction

  // Instruction decode and weight-FSM next state
  always_comb begin
    w_flush      = 1'b0;
`ifdef MAC_TILE_WFLUSH_EN
    w_flush      = (inst_w == 2'b11);
`endif
    w_load       = (inst_w == 2'b01);
    w_exec       = inst_w[1] & ~w_flush;
    w_wstate_nxt = r_wstate;
    w_wr_b1      = 1'b0;
    w_wr_b2      = 1'b0;
    if (w_flush) begin
      w_wstate_nxt = W_EMPTY;
    end else if (w_load) begin
      case (r_wstate)
        W_EMPTY: begin
          w_wr_b1 = 1'b1;
          if (r_mode) begin
            w_wstate_nxt = W_HALF;
          end else begin
            w_wr_b2      = 1'b1;
            w_wstate_nxt = W_READY;
          end
        end
        W_HALF: begin
          w_wr_b2      = 1'b1;
          w_wstate_nxt = W_READY;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_wstate <= W_EMPTY;
    else       r_wstate <= w_wstate_nxt;
  end

  // Register stage: weights, activation, psum, forwarded instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= 1'b0;
      r_b1   <= '0;
      r_b2   <= '0;
      r_a    <= '0;
      r_c    <= '0;
      r_inst <= 2'b00;
    end else begin
      // SIMD mode is frozen once the first weight has been taken.
      if (r_wstate == W_EMPTY) r_mode <= act_mode;
      if (w_flush) begin
        r_b1 <= '0;
        r_b2 <= '0;
      end else begin
        if (w_wr_b1) r_b1 <= $signed(in_w);
        if (w_wr_b2) r_b2 <= $signed(in_w);
      end
      if ((inst_w != 2'b00) && !w_flush) r_a <= in_w;
      if (w_exec) r_c <= $signed(in_n);
      // Loads consumed here are not forwarded; only loads seen in W_READY go east.
      if (w_flush) r_inst <= 2'b11;
      else         r_inst <= {inst_w[1], inst_w[0] & ~inst_w[1] & (r_wstate == W_READY)};
    end
  end

  // Combinational MAC from the registered operands
  always_comb begin
    w_a_lo = {{(bw-HW){1'b0}}, r_a[HW-1:0]};
    w_a_hi = {{HW{1'b0}}, r_a[bw-1:HW]};
    w_p0   = mul_uw(r_a, r_b1);
    w_p1   = mul_uw(w_a_lo, r_b1);
    w_p2   = mul_uw(w_a_hi, r_b2);
    if (r_mode) out_s = r_c + w_p1 + w_p2;
    else        out_s = r_c + w_p0;
  end

  assign out_e  = r_a;
  assign inst_e = r_inst;

endmodule
